// File: rtl/cv32e40x_rvfi_pkg.sv
// RVFI shared types: the retire record buffered by the trace FIFO and
// a helper that reports which memory-operation slots carry traffic.
package cv32e40x_rvfi_pkg;

    localparam int NMEM        = 2;
    localparam int MEMOP_IDX_W = (NMEM > 1) ? $clog2(NMEM) : 1;

    typedef struct packed {
        logic [31:0]        pc_rdata;
        logic [4:0]         rs1_addr;
        logic [4:0]         rs2_addr;
        logic [4:0]         rd_addr;
        logic [31:0]        rs1_rdata;
        logic [31:0]        rs2_rdata;
        logic [31:0]        rd_wdata;
        logic [32*NMEM-1:0] mem_addr;
        logic [32*NMEM-1:0] mem_rdata;
        logic [32*NMEM-1:0] mem_wdata;
        logic [4*NMEM-1:0]  mem_rmask;
        logic [4*NMEM-1:0]  mem_wmask;
    } rvfi_trace_rec_t;

    // A slot is active when either of its byte masks has a bit set.
    function automatic logic [NMEM-1:0] rvfi_memop_active(input rvfi_trace_rec_t rec);
        logic [NMEM-1:0] act;
        act = '0;
        for (int i = 0; i < NMEM; i++) begin
            act[i] = |(rec.mem_rmask[4*i +: 4] | rec.mem_wmask[4*i +: 4]);
        end
        return act;
    endfunction

endpackage

// File: rtl/cv32e40x_rvfi_trace_fifo_if.sv
// Retire-record input and trace-beat output bundle of the RVFI trace FIFO.
interface cv32e40x_rvfi_trace_fifo_if
    import cv32e40x_rvfi_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   rvfi_valid;
    logic [31:0]            rvfi_pc_rdata;
    logic [4:0]             rvfi_rs1_addr;
    logic [4:0]             rvfi_rs2_addr;
    logic [4:0]             rvfi_rd_addr;
    logic [31:0]            rvfi_rs1_rdata;
    logic [31:0]            rvfi_rs2_rdata;
    logic [31:0]            rvfi_rd_wdata;
    logic [32*NMEM-1:0]     rvfi_mem_addr;
    logic [32*NMEM-1:0]     rvfi_mem_rdata;
    logic [32*NMEM-1:0]     rvfi_mem_wdata;
    logic [4*NMEM-1:0]      rvfi_mem_rmask;
    logic [4*NMEM-1:0]      rvfi_mem_wmask;

    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_pc;
    logic [31:0]            out_rs1_rdata;
    logic [31:0]            out_rs2_rdata;
    logic [31:0]            out_rd_wdata;
    logic [4:0]             out_rs1_addr;
    logic [4:0]             out_rs2_addr;
    logic [4:0]             out_rd_addr;
    logic [31:0]            out_mem_addr;
    logic [31:0]            out_mem_rdata;
    logic [31:0]            out_mem_wdata;
    logic [3:0]             out_mem_rmask;
    logic [3:0]             out_mem_wmask;
    logic [MEMOP_IDX_W-1:0] out_memop_idx;
    logic                   out_last;
    logic                   overflow;
    logic [CNT_W-1:0]       count;

    modport master (
        output rvfi_valid, rvfi_pc_rdata, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
               rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr,
               rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask, out_ready,
        input  out_valid, out_pc, out_rs1_rdata, out_rs2_rdata, out_rd_wdata,
               out_rs1_addr, out_rs2_addr, out_rd_addr, out_mem_addr, out_mem_rdata,
               out_mem_wdata, out_mem_rmask, out_mem_wmask, out_memop_idx, out_last,
               overflow, count
    );

    modport slave (
        input  rvfi_valid, rvfi_pc_rdata, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
               rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr,
               rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask, out_ready,
        output out_valid, out_pc, out_rs1_rdata, out_rs2_rdata, out_rd_wdata,
               out_rs1_addr, out_rs2_addr, out_rd_addr, out_mem_addr, out_mem_rdata,
               out_mem_wdata, out_mem_rmask, out_mem_wmask, out_memop_idx, out_last,
               overflow, count
    );

endinterface

// File: rtl/cv32e40x_rvfi_memop_sel.sv
// Picks the first active memory slot, the next active slot above idx, and
// whether idx is the final active slot of a record.
module cv32e40x_rvfi_memop_sel
    import cv32e40x_rvfi_pkg::*;
(
    input  logic [NMEM-1:0]        active,
    input  logic [MEMOP_IDX_W-1:0] idx,
    output logic [MEMOP_IDX_W-1:0] first_idx,
    output logic [MEMOP_IDX_W-1:0] next_idx,
    output logic                   is_last
);

    // Scanning downward lets the lowest qualifying slot win.
    always_comb begin
        first_idx = '0;
        next_idx  = idx;
        is_last   = 1'b1;
        for (int i = NMEM - 1; i >= 0; i--) begin
            if (active[i]) first_idx = MEMOP_IDX_W'(i);
            if (active[i] && (i > int'(idx))) begin
                next_idx = MEMOP_IDX_W'(i);
                is_last  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cv32e40x_rvfi_trace_fifo.sv
// Buffers RVFI retire records and serializes each into one trace beat per
// active memory slot (one beat when none), flagging records lost to overflow.
module cv32e40x_rvfi_trace_fifo
    import cv32e40x_rvfi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                        clk,
    input logic                        rst,
    cv32e40x_rvfi_trace_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {EMPTY, EMIT} state_e;

    state_e                 state;
    rvfi_trace_rec_t        mem_q [DEPTH];
    logic [PTR_W-1:0]       head_q, tail_q, head_nxt;
    logic [CNT_W-1:0]       count_q;
    logic [MEMOP_IDX_W-1:0] idx_q;
    logic                   overflow_q;

    rvfi_trace_rec_t        in_rec, head_rec, nxt_rec;
    logic [MEMOP_IDX_W-1:0] head_first, head_next, nxt_first, nxt_next;
    logic                   head_last, nxt_last;
    logic                   out_valid, hs, pop, push;

    always_comb begin
        in_rec           = '0;
        in_rec.pc_rdata  = bus.rvfi_pc_rdata;
        in_rec.rs1_addr  = bus.rvfi_rs1_addr;
        in_rec.rs2_addr  = bus.rvfi_rs2_addr;
        in_rec.rd_addr   = bus.rvfi_rd_addr;
        in_rec.rs1_rdata = bus.rvfi_rs1_rdata;
        in_rec.rs2_rdata = bus.rvfi_rs2_rdata;
        in_rec.rd_wdata  = bus.rvfi_rd_wdata;
        in_rec.mem_addr  = bus.rvfi_mem_addr;
        in_rec.mem_rdata = bus.rvfi_mem_rdata;
        in_rec.mem_wdata = bus.rvfi_mem_wdata;
        in_rec.mem_rmask = bus.rvfi_mem_rmask;
        in_rec.mem_wmask = bus.rvfi_mem_wmask;
    end

    assign head_nxt  = head_q + 1'b1;
    assign head_rec  = mem_q[head_q];
    // The record that becomes head next: already stored, or the one arriving now.
    assign nxt_rec   = (count_q > CNT_W'(1)) ? mem_q[head_nxt] : in_rec;

    assign out_valid = (state == EMIT);
    assign hs        = out_valid & bus.out_ready;
    assign pop       = hs & head_last;
    assign push      = bus.rvfi_valid & ((count_q < CNT_W'(DEPTH)) | pop);

    cv32e40x_rvfi_memop_sel u_sel_head (
        .active    (rvfi_memop_active(head_rec)),
        .idx       (idx_q),
        .first_idx (head_first),
        .next_idx  (head_next),
        .is_last   (head_last)
    );

    cv32e40x_rvfi_memop_sel u_sel_nxt (
        .active    (rvfi_memop_active(nxt_rec)),
        .idx       ('0),
        .first_idx (nxt_first),
        .next_idx  (nxt_next),
        .is_last   (nxt_last)
    );

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= in_rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.rvfi_valid && !push) overflow_q <= 1'b1;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_nxt;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            case (state)
                EMPTY: begin
                    if (push) begin
                        state <= EMIT;
                        idx_q <= nxt_first;
                    end
                end
                EMIT: begin
                    if (pop) begin
                        if (count_q > CNT_W'(1) || push) begin
                            idx_q <= nxt_first;
                        end else begin
                            state <= EMPTY;
                            idx_q <= '0;
                        end
                    end else if (hs) begin
                        idx_q <= head_next;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.out_valid     = out_valid;
    assign bus.out_pc        = out_valid ? head_rec.pc_rdata  : '0;
    assign bus.out_rs1_addr  = out_valid ? head_rec.rs1_addr  : '0;
    assign bus.out_rs2_addr  = out_valid ? head_rec.rs2_addr  : '0;
    assign bus.out_rd_addr   = out_valid ? head_rec.rd_addr   : '0;
    assign bus.out_rs1_rdata = out_valid ? head_rec.rs1_rdata : '0;
    assign bus.out_rs2_rdata = out_valid ? head_rec.rs2_rdata : '0;
    assign bus.out_rd_wdata  = out_valid ? head_rec.rd_wdata  : '0;
    assign bus.out_mem_addr  = out_valid ? head_rec.mem_addr[32*idx_q +: 32]  : '0;
    assign bus.out_mem_rdata = out_valid ? head_rec.mem_rdata[32*idx_q +: 32] : '0;
    assign bus.out_mem_wdata = out_valid ? head_rec.mem_wdata[32*idx_q +: 32] : '0;
    assign bus.out_mem_rmask = out_valid ? head_rec.mem_rmask[4*idx_q +: 4]   : '0;
    assign bus.out_mem_wmask = out_valid ? head_rec.mem_wmask[4*idx_q +: 4]   : '0;
    assign bus.out_memop_idx = out_valid ? idx_q : '0;
    assign bus.out_last      = out_valid & head_last;
    assign bus.overflow      = overflow_q;
    assign bus.count         = count_q;

endmodule
